// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, field positions, writable-field masks and exception codes
// for the LoongArch CSR bank.
package csr_file_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_PLV_LSB      = 0;
    localparam int CRMD_IE_BIT       = 2;
    localparam int PRMD_PPLV_LSB     = 0;
    localparam int PRMD_PIE_BIT      = 2;
    localparam int ESTAT_IS_MSB      = 12;
    localparam int TCFG_EN_BIT       = 0;
    localparam int TCFG_PERIODIC_BIT = 1;
    localparam int TCFG_INITVAL_LSB  = 2;
    localparam int TICLR_CLR_BIT     = 0;

    // Software-writable bits; everything outside these stays 0 and reads 0.
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1FFF;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

    localparam logic [5:0] ECODE_ADE = 6'h8;
    localparam logic [5:0] ECODE_ALE = 6'h9;
    localparam logic [5:0] ECODE_SYS = 6'hB;

    typedef struct packed {
        logic [8:0] esubcode;
        logic [5:0] ecode;
        logic       ipi;
        logic [7:0] hw;
        logic [1:0] sw;
    } estat_t;

    function automatic logic [31:0] masked_wr(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// WB/ID/IF-facing CSR interface. master = pipeline side, slave = csr_file.
interface csr_file_if;
    // No valid/ready: csr_we, wb_ex and ertn_flush are single-cycle strobes already
    // qualified by WB valid; every strobe is consumed at the next clock edge.
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rd_value;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] era_pc;
    logic        has_int;

    modport master (
        output csr_rd_num, csr_we, csr_wr_num, csr_wr_mask, csr_wr_value,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        input  csr_rd_value, ex_entry, era_pc, has_int
    );

    modport slave (
        input  csr_rd_num, csr_we, csr_wr_num, csr_wr_mask, csr_wr_value,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        output csr_rd_value, ex_entry, era_pc, has_int
    );

endinterface

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer; owns the timer interrupt bit ESTAT.IS[11].
module csr_timer
    import csr_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tcfg_we_i,
    input  logic [31:0] tcfg_wdata_i,
    input  logic        ticlr_i,
    output logic [31:0] tcfg_o,
    output logic [31:0] tval_o,
    output logic        ti_o
);
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic        ti_q, ti_d;

    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_d   = ti_q;
        if (ticlr_i) ti_d = 1'b0;
        // A TCFG write overrides any countdown step in the same cycle.
        if (tcfg_we_i) begin
            tcfg_d = tcfg_wdata_i;
            tval_d = {tcfg_wdata_i[31:TCFG_INITVAL_LSB], 2'b00};
        end else if (tcfg_q[TCFG_EN_BIT]) begin
            if (tval_q != 32'd0) begin
                tval_d = tval_q - 32'd1;
                if (tval_q == 32'd1) ti_d = 1'b1;
            end else if (tcfg_q[TCFG_PERIODIC_BIT]) begin
                tval_d = {tcfg_q[31:TCFG_INITVAL_LSB], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcfg_q <= '0;
            tval_q <= 32'hFFFF_FFFF;
            ti_q   <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            ti_q   <= ti_d;
        end
    end

    assign tcfg_o = tcfg_q;
    assign tval_o = tval_q;
    assign ti_o   = ti_q;

endmodule

// File: rtl/csr_file.sv
// Architectural CSR bank: masked software writes, exception/ertn commits,
// combinational read port and the pending-interrupt flag.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] TID_INIT    = 32'h0,
    parameter logic [5:0]  EX_ADE_CODE = ECODE_ADE,
    parameter logic [5:0]  EX_ALE_CODE = ECODE_ALE
) (
    input  logic      clk,
    input  logic      resetn,
    csr_file_if.slave bus
);
    logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
    logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
    logic [3:0][31:0] save_q, save_d;
    estat_t      estat_q, estat_d;
    logic        sw_we, tcfg_we, ticlr_we, timer_int;
    logic [31:0] wr_val, wr_mask, tcfg_wdata, tcfg_q, tval_q, estat_rd, rd_value;

    // Exception beats ertn beats software write; losers are dropped, not deferred.
    assign sw_we      = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
    assign wr_val     = bus.csr_wr_value;
    assign wr_mask    = bus.csr_wr_mask;
    assign tcfg_we    = sw_we & (bus.csr_wr_num == CSR_TCFG);
    assign ticlr_we   = sw_we & (bus.csr_wr_num == CSR_TICLR)
                      & wr_val[TICLR_CLR_BIT] & wr_mask[TICLR_CLR_BIT];
    assign tcfg_wdata = masked_wr(tcfg_q, wr_val, wr_mask);

    csr_timer u_timer (
        .clk          (clk),
        .rst_n        (resetn),
        .tcfg_we_i    (tcfg_we),
        .tcfg_wdata_i (tcfg_wdata),
        .ticlr_i      (ticlr_we),
        .tcfg_o       (tcfg_q),
        .tval_o       (tval_q),
        .ti_o         (timer_int)
    );

    assign estat_rd = {1'b0, estat_q.esubcode, estat_q.ecode, 3'b000, estat_q.ipi,
                       timer_int, 1'b0, estat_q.hw, estat_q.sw};

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;
        estat_d  = estat_q;
        estat_d.hw  = bus.hw_int_in;
        estat_d.ipi = bus.ipi_int_in;
        if (bus.wb_ex) begin
            prmd_d[PRMD_PPLV_LSB +: 2] = crmd_q[CRMD_PLV_LSB +: 2];
            prmd_d[PRMD_PIE_BIT]       = crmd_q[CRMD_IE_BIT];
            crmd_d[CRMD_PLV_LSB +: 2]  = 2'b00;
            crmd_d[CRMD_IE_BIT]        = 1'b0;
            estat_d.ecode    = bus.wb_ecode;
            estat_d.esubcode = bus.wb_esubcode;
            era_d            = bus.wb_pc;
            if (bus.wb_ecode == EX_ADE_CODE || bus.wb_ecode == EX_ALE_CODE)
                badv_d = bus.wb_vaddr;
        end else if (bus.ertn_flush) begin
            crmd_d[CRMD_PLV_LSB +: 2] = prmd_q[PRMD_PPLV_LSB +: 2];
            crmd_d[CRMD_IE_BIT]       = prmd_q[PRMD_PIE_BIT];
        end else if (sw_we) begin
            case (bus.csr_wr_num)
                CSR_CRMD:   crmd_d   = masked_wr(crmd_q, wr_val, wr_mask & CRMD_WMASK);
                CSR_PRMD:   prmd_d   = masked_wr(prmd_q, wr_val, wr_mask & PRMD_WMASK);
                CSR_ECFG:   ecfg_d   = masked_wr(ecfg_q, wr_val, wr_mask & ECFG_WMASK);
                CSR_ESTAT:  estat_d.sw = (estat_q.sw & ~wr_mask[1:0]) | (wr_val[1:0] & wr_mask[1:0]);
                CSR_ERA:    era_d    = masked_wr(era_q, wr_val, wr_mask);
                CSR_BADV:   badv_d   = masked_wr(badv_q, wr_val, wr_mask);
                CSR_EENTRY: eentry_d = masked_wr(eentry_q, wr_val, wr_mask & EENTRY_WMASK);
                CSR_SAVE0:  save_d[0] = masked_wr(save_q[0], wr_val, wr_mask);
                CSR_SAVE1:  save_d[1] = masked_wr(save_q[1], wr_val, wr_mask);
                CSR_SAVE2:  save_d[2] = masked_wr(save_q[2], wr_val, wr_mask);
                CSR_SAVE3:  save_d[3] = masked_wr(save_q[3], wr_val, wr_mask);
                CSR_TID:    tid_d    = masked_wr(tid_q, wr_val, wr_mask);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= CRMD_RESET;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tid_q    <= TID_INIT;
            save_q   <= '0;
            estat_q  <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            save_q   <= save_d;
            estat_q  <= estat_d;
        end
    end

    // Same-cycle writes are deliberately not bypassed; ID interlocks instead.
    always_comb begin
        rd_value = '0;
        case (bus.csr_rd_num)
            CSR_CRMD:   rd_value = crmd_q;
            CSR_PRMD:   rd_value = prmd_q;
            CSR_ECFG:   rd_value = ecfg_q;
            CSR_ESTAT:  rd_value = estat_rd;
            CSR_ERA:    rd_value = era_q;
            CSR_BADV:   rd_value = badv_q;
            CSR_EENTRY: rd_value = eentry_q;
            CSR_SAVE0:  rd_value = save_q[0];
            CSR_SAVE1:  rd_value = save_q[1];
            CSR_SAVE2:  rd_value = save_q[2];
            CSR_SAVE3:  rd_value = save_q[3];
            CSR_TID:    rd_value = tid_q;
            CSR_TCFG:   rd_value = tcfg_q;
            CSR_TVAL:   rd_value = tval_q;
            default:    rd_value = '0;
        endcase
    end

    assign bus.csr_rd_value = rd_value;
    assign bus.ex_entry     = eentry_q;
    assign bus.era_pc       = era_q;
    assign bus.has_int      = crmd_q[CRMD_IE_BIT]
                            & |(estat_rd[ESTAT_IS_MSB:0] & ecfg_q[ESTAT_IS_MSB:0]);

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a flat per-address CSR model checked every cycle,
// plus hand-computed expectations for the key scenarios.
`timescale 1ns/1ps
module tb_csr_file;
  localparam int A_CRMD = 'h0, A_PRMD = 'h1, A_ECFG = 'h4, A_ESTAT = 'h5, A_ERA = 'h6;
  localparam int A_BADV = 'h7, A_EENTRY = 'hC, A_SAVE0 = 'h30, A_SAVE1 = 'h31;
  localparam int A_TID = 'h40, A_TCFG = 'h41, A_TVAL = 'h42, A_TICLR = 'h44;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  logic [31:0] m_csr [0:127];
  logic [31:0] m_nxt [0:127];
  logic [31:0] exp_q[$];

  csr_file_if bus();

  csr_file dut (.clk(clk), .resetn(resetn), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: one word per address; bits outside the writable set never change
  function automatic logic [31:0] wmask(input int a);
    case (a)
      A_CRMD:  return 32'h0000_01FF;
      A_PRMD:  return 32'h0000_0007;
      A_ECFG:  return 32'h0000_1FFF;
      A_ESTAT: return 32'h0000_0003;
      A_EENTRY: return 32'hFFFF_FFC0;
      A_ERA, A_BADV, 'h30, 'h31, 'h32, 'h33, A_TID, A_TCFG: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    if (a >= 14'd128) return 32'h0;
    return m_csr[a[6:0]];
  endfunction

  function automatic logic model_has_int();
    return m_csr[A_CRMD][2] & (|(m_csr[A_ESTAT][12:0] & m_csr[A_ECFG][12:0]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_csr[i] = 32'h0;
    m_csr[A_CRMD] = 32'h8;
    m_csr[A_TVAL] = 32'hFFFF_FFFF;
  endtask

  task automatic model_next();
    logic [31:0] wm;
    int a;
    logic tcfg_wr;
    for (int i = 0; i < 128; i++) m_nxt[i] = m_csr[i];
    tcfg_wr = 1'b0;
    if (bus.wb_ex) begin
      m_nxt[A_PRMD][2:0] = m_csr[A_CRMD][2:0];
      m_nxt[A_CRMD][2:0] = 3'b000;
      m_nxt[A_ESTAT][21:16] = bus.wb_ecode;
      m_nxt[A_ESTAT][30:22] = bus.wb_esubcode;
      m_nxt[A_ERA] = bus.wb_pc;
      if (bus.wb_ecode == 6'h8 || bus.wb_ecode == 6'h9) m_nxt[A_BADV] = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      m_nxt[A_CRMD][2:0] = m_csr[A_PRMD][2:0];
    end else if (bus.csr_we && bus.csr_wr_num < 14'd128) begin
      a = int'(bus.csr_wr_num);
      wm = wmask(a) & bus.csr_wr_mask;
      m_nxt[a] = (m_csr[a] & ~wm) | (bus.csr_wr_value & wm);
      if (a == A_TCFG) begin
        tcfg_wr = 1'b1;
        m_nxt[A_TVAL] = {m_nxt[A_TCFG][31:2], 2'b00};
      end
      if (a == A_TICLR && bus.csr_wr_value[0] && bus.csr_wr_mask[0]) m_nxt[A_ESTAT][11] = 1'b0;
    end
    m_nxt[A_ESTAT][9:2] = bus.hw_int_in;
    m_nxt[A_ESTAT][12]  = bus.ipi_int_in;
    if (!tcfg_wr && m_csr[A_TCFG][0]) begin
      if (m_csr[A_TVAL] != 32'h0) begin
        m_nxt[A_TVAL] = m_csr[A_TVAL] - 32'h1;
        if (m_csr[A_TVAL] == 32'h1) m_nxt[A_ESTAT][11] = 1'b1;
      end else if (m_csr[A_TCFG][1]) begin
        m_nxt[A_TVAL] = {m_csr[A_TCFG][31:2], 2'b00};
      end
    end
  endtask

  task automatic cycle_check();
    check("cyc_rd", bus.csr_rd_value, model_read(bus.csr_rd_num));
    check("cyc_ex_entry", bus.ex_entry, m_csr[A_EENTRY]);
    check("cyc_era_pc", bus.era_pc, m_csr[A_ERA]);
    check("cyc_has_int", {31'b0, bus.has_int}, {31'b0, model_has_int()});
  endtask

  // driver tasks: inputs change at posedge+1, compare and model step at negedge
  task automatic tick();
    @(negedge clk);
    cycle_check();
    model_next();
    @(posedge clk);
    for (int i = 0; i < 128; i++) m_csr[i] = m_nxt[i];
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
    bus.csr_we = 1'b1;
    bus.csr_wr_num = a;
    bus.csr_wr_value = v;
    bus.csr_wr_mask = m;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic ex(input logic [5:0] ec, input logic [8:0] esub,
                    input logic [31:0] pc, input logic [31:0] va);
    bus.wb_ex = 1'b1;
    bus.wb_ecode = ec;
    bus.wb_esubcode = esub;
    bus.wb_pc = pc;
    bus.wb_vaddr = va;
    tick();
    bus.wb_ex = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
    bus.csr_rd_num = a;
    #1;
    check(name, bus.csr_rd_value, exp);
  endtask

  // scoreboard for the periodic countdown: expected TVAL after each cycle
  task automatic tval_sequence();
    for (int v = 7; v >= 1; v--) exp_q.push_back(32'(v));
    while (exp_q.size() != 0) begin
      tick();
      read_chk("tval_count", 14'(A_TVAL), exp_q.pop_front());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.csr_rd_num = '0; bus.csr_we = 1'b0; bus.csr_wr_num = '0;
    bus.csr_wr_mask = '0; bus.csr_wr_value = '0; bus.wb_ex = 1'b0;
    bus.wb_ecode = '0; bus.wb_esubcode = '0; bus.wb_pc = '0; bus.wb_vaddr = '0;
    bus.ertn_flush = 1'b0; bus.hw_int_in = '0; bus.ipi_int_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    // reset values
    read_chk("rst_crmd", 14'(A_CRMD), 32'h8);
    read_chk("rst_tval", 14'(A_TVAL), 32'hFFFF_FFFF);
    read_chk("rst_estat", 14'(A_ESTAT), 32'h0);
    read_chk("rst_tid", 14'(A_TID), 32'h0);
    check("rst_has_int", {31'b0, bus.has_int}, 32'h0);

    // masked write, no same-cycle bypass
    wr(14'(A_SAVE0), 32'h1234_5678, 32'hFFFF_FFFF);
    bus.csr_we = 1'b1; bus.csr_wr_num = 14'(A_SAVE0);
    bus.csr_wr_value = 32'hDEAD_BEEF; bus.csr_wr_mask = 32'h0000_FFFF;
    read_chk("save0_write_cycle", 14'(A_SAVE0), 32'h1234_5678);
    tick();
    bus.csr_we = 1'b0;
    read_chk("save0_masked", 14'(A_SAVE0), 32'h1234_BEEF);

    // exception entry and ertn
    wr(14'(A_CRMD), 32'h7, 32'h7);
    read_chk("crmd_plv3_ie", 14'(A_CRMD), 32'hF);
    ex(6'hB, 9'h0, 32'h1C00_0100, 32'h0);
    read_chk("ex_era", 14'(A_ERA), 32'h1C00_0100);
    read_chk("ex_prmd", 14'(A_PRMD), 32'h7);
    read_chk("ex_crmd", 14'(A_CRMD), 32'h8);
    read_chk("ex_estat", 14'(A_ESTAT), 32'h000B_0000);
    check("ex_era_pc", bus.era_pc, 32'h1C00_0100);
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
    read_chk("ertn_crmd", 14'(A_CRMD), 32'hF);

    // all three events at once: only the exception lands
    wr(14'(A_SAVE1), 32'h1111_1111, 32'hFFFF_FFFF);
    bus.csr_we = 1'b1; bus.csr_wr_num = 14'(A_SAVE1);
    bus.csr_wr_value = 32'h2222_2222; bus.csr_wr_mask = 32'hFFFF_FFFF;
    bus.ertn_flush = 1'b1;
    ex(6'h1, 9'h0, 32'h1C00_0200, 32'h0);
    bus.csr_we = 1'b0; bus.ertn_flush = 1'b0;
    read_chk("prio_save1", 14'(A_SAVE1), 32'h1111_1111);
    read_chk("prio_crmd", 14'(A_CRMD), 32'h8);
    read_chk("prio_era", 14'(A_ERA), 32'h1C00_0200);

    // BADV capture on address-error codes only
    ex(6'h8, 9'h1, 32'h1C00_0300, 32'h0000_0003);
    read_chk("adem_badv", 14'(A_BADV), 32'h3);
    read_chk("adem_estat", 14'(A_ESTAT), 32'h0048_0000);
    ex(6'hB, 9'h0, 32'h1C00_0304, 32'h0000_1234);
    read_chk("sys_badv", 14'(A_BADV), 32'h3);

    // periodic timer
    wr(14'(A_CRMD), 32'h4, 32'h4);
    wr(14'(A_ECFG), 32'h0000_0800, 32'hFFFF_FFFF);
    wr(14'(A_TCFG), 32'h0000_000B, 32'hFFFF_FFFF);
    read_chk("tcfg_load", 14'(A_TVAL), 32'h8);
    tval_sequence();
    read_chk("pre_hit_estat", 14'(A_ESTAT), 32'h000B_0000);
    tick();
    read_chk("hit_tval", 14'(A_TVAL), 32'h0);
    read_chk("hit_estat", 14'(A_ESTAT), 32'h000B_0800);
    check("hit_has_int", {31'b0, bus.has_int}, 32'h1);
    tick();
    read_chk("reload_tval", 14'(A_TVAL), 32'h8);
    wr(14'(A_TICLR), 32'h1, 32'hFFFF_FFFF);
    read_chk("ticlr_estat", 14'(A_ESTAT), 32'h000B_0000);
    read_chk("ticlr_reads0", 14'(A_TICLR), 32'h0);
    check("ticlr_has_int", {31'b0, bus.has_int}, 32'h0);

    // one-shot timer; reload wins over the pending decrement
    wr(14'(A_TCFG), 32'h0000_0005, 32'hFFFF_FFFF);
    read_chk("oneshot_load", 14'(A_TVAL), 32'h4);
    repeat (4) tick();
    read_chk("oneshot_estat", 14'(A_ESTAT), 32'h000B_0800);
    wr(14'(A_TICLR), 32'h1, 32'h1);
    repeat (3) tick();
    read_chk("oneshot_hold", 14'(A_TVAL), 32'h0);
    read_chk("oneshot_no_reirq", 14'(A_ESTAT), 32'h000B_0000);

    // level interrupt sampling, EENTRY low bits, unimplemented address
    bus.hw_int_in = 8'hA5; bus.ipi_int_in = 1'b1;
    tick();
    read_chk("hw_ipi_estat", 14'(A_ESTAT), 32'h000B_1294);
    bus.hw_int_in = 8'h00; bus.ipi_int_in = 1'b0;
    wr(14'(A_EENTRY), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("eentry_low0", 14'(A_EENTRY), 32'hFFFF_FFC0);
    check("ex_entry_out", bus.ex_entry, 32'hFFFF_FFC0);
    wr(14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_chk("unimpl_rd", 14'h002, 32'h0);

    // asynchronous reset mid-count
    wr(14'(A_TCFG), 32'h0000_0101, 32'hFFFF_FFFF);
    repeat (3) tick();
    read_chk("midcount_tval", 14'(A_TVAL), 32'h0000_00FD);
    #2;
    resetn = 1'b0;
    model_reset();
    read_chk("async_rst_tval", 14'(A_TVAL), 32'hFFFF_FFFF);
    read_chk("async_rst_tcfg", 14'(A_TCFG), 32'h0);
    read_chk("async_rst_estat", 14'(A_ESTAT), 32'h0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) tick();
    read_chk("post_rst_tval", 14'(A_TVAL), 32'hFFFF_FFFF);
    read_chk("post_rst_crmd", 14'(A_CRMD), 32'h8);
    tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Architectural CSR bank for the LoongArch pipeline; the responder end of the WB-stage CSR/exception interface.
- Consumes masked CSR writes, exception commits and ertn commits from WB.
- Returns combinational CSR read data to ID, the exception entry and return PCs to IF, and the pending-interrupt flag to ID.
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL, TICLR, including the timer counter.

Parameters:
- TID_INIT, 32'h0, reset value of TID.
- EX_ADE_CODE, 6'h8, Ecode for ADEF/ADEM; BADV captures on this code.
- EX_ALE_CODE, 6'h9, Ecode for ALE; BADV captures on this code.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- csr_rd_num  in  14  read address from ID
- csr_rd_value  out  32  combinational read data
- csr_we  in  1  write enable, already qualified by WB valid
- csr_wr_num  in  14  write address
- csr_wr_mask  in  32  bitwise write mask
- csr_wr_value  in  32  write data
- wb_ex  in  1  exception commit, qualified by WB valid
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_pc  in  32  PC of the excepting instruction
- wb_vaddr  in  32  faulting address
- ertn_flush  in  1  ertn commit
- hw_int_in  in  8  hardware interrupt lines, level
- ipi_int_in  in  1  inter-processor interrupt, level
- ex_entry  out  32  EENTRY value
- era_pc  out  32  ERA value
- has_int  out  1  interrupt pending and enabled

Behaviour:
- Reset is asynchronous and active-low. All CSRs clear on reset, with these exceptions:
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - TID = TID_INIT.
  - TVAL = 32'hFFFFFFFF.
- Masked write: new = (old & ~mask) | (value & mask). It applies only to software-writable fields and takes effect at the next edge. Read-only and reserved bits read 0.
- The read port is combinational from the current register state. A write in the same cycle is not bypassed; ID interlocks on it.
- An unimplemented CSR address reads 0, and writes to it are ignored.
- Event priority within a cycle: wb_ex > ertn_flush > csr_we. The losing events are dropped entirely.
- On wb_ex:
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ESTAT.Ecode <= wb_ecode; ESTAT.EsubCode <= wb_esubcode.
  - ERA <= wb_pc.
  - BADV <= wb_vaddr when wb_ecode is EX_ADE_CODE or EX_ALE_CODE.
- On ertn_flush: CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- EENTRY[5:0] is hardwired to 0. ex_entry = EENTRY; era_pc = ERA. Both are direct register outputs.
- ESTAT.IS sources:
  - IS[1:0] are software-writable.
  - IS[9:2] <= hw_int_in every cycle.
  - IS[12] <= ipi_int_in every cycle.
  - IS[11] is the timer bit, described below.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). It is registered-state based, with no same-cycle input path.
- Timer:
  - Writing TCFG loads TVAL <= {new InitVal[31:2], 2'b00}.
  - When TCFG.En=1 and TVAL != 0, TVAL decrements by 1 each cycle.
  - The cycle TVAL goes from 1 to 0, IS[11] sets.
  - In periodic mode, TVAL reloads {InitVal, 2'b00} the following cycle.
  - In non-periodic mode, TVAL holds at 0 with no further interrupts.
  - When En=0, TVAL holds.
- TICLR: writing bit0=1 clears IS[11]. TICLR always reads 0. If a timer set and a TICLR clear land in the same cycle, the set wins.
- A TCFG write in the same cycle as a decrement uses the write's reload value; the decrement is dropped.
- Reset mid-count: TVAL returns to all-ones, En=0, and IS[11]=0.

Decomposition:
- Shared package holds:
  - The CSR address constants (CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44).
  - The field bit positions.
  - The Ecode constants.
- One sub-module, csr_timer, holds TCFG, TVAL and the timer interrupt pulse.

Test Plan:
- Reset, then read CRMD -> 32'h8; TVAL -> 32'hFFFFFFFF; ESTAT -> 0; has_int = 0.
- Write SAVE0 with value 32'hDEADBEEF and mask 32'h0000FFFF over old 32'h12345678 -> SAVE0 reads 32'h1234BEEF the next cycle, and 32'h12345678 in the write cycle.
- With CRMD.PLV=3 and IE=1, pulse wb_ex (ecode 6'hB, pc 32'h1C000100) -> ERA=32'h1C000100; PRMD=32'h7; CRMD.PLV=0, IE=0; ESTAT[21:16]=6'hB. Then ertn_flush -> CRMD.PLV=3, IE=1.
- Assert wb_ex, ertn_flush and csr_we (to SAVE1) in the same cycle -> only the exception updates occur; SAVE1 and CRMD.PLV are unchanged by ertn.
- Write TCFG = 32'h0000000B (En, Periodic, InitVal=2) -> TVAL reads 8, then decrements to 0. IS[11] sets the cycle TVAL hits 0, and TVAL reloads 8 the next cycle. With ECFG.LIE[11]=1 and IE=1, has_int=1. A TICLR write of 1 clears IS[11].
- ADEM exception with wb_vaddr 32'h00000003 -> BADV=3. A following syscall (6'hB) leaves BADV=3.
